// File: rtl/prbs52_checker.sv
// Self-synchronising checker for the 52-bit Fibonacci PRBS (taps 51,3,2,0).
// Optional reconstructed word output enabled by defining PRBS52_WORD_OUT_EN.
module prbs52_checker #(
  parameter int LOCK_CNT  = 64,
  parameter int ERR_LIMIT = 8,
  parameter int WINDOW    = 256,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr_counts,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
`ifdef PRBS52_WORD_OUT_EN
  ,
  output logic [51:0]      word_out,
  output logic             word_valid
`endif
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(WINDOW + 1);
  localparam logic [5:0] FILL_LAST = 6'd51;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [51:0]        s_q, s_d;
  logic [5:0]         fill_q, fill_d;
  logic [15:0]        match_q, match_d;
  logic [WIN_W-1:0]   window_q, window_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic               pred;
  logic               mismatch;
  logic [51:0]        s_shift;
  logic [51:0]        s_fly;
  logic [WERR_W-1:0]  werr_inc;

`ifdef PRBS52_WORD_OUT_EN
  logic [5:0]         wcnt_q, wcnt_d;
  logic [51:0]        word_q, word_d;
  logic               word_valid_q, word_valid_d;
`endif

  always_comb begin
    pred     = s_q[51] ^ s_q[3] ^ s_q[2] ^ s_q[0];
    mismatch = bit_in ^ pred;
    s_shift  = {s_q[50:0], bit_in};
    s_fly    = {s_q[50:0], pred};
    werr_inc = werr_q + WERR_W'(mismatch);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  // An all-zero fill is the LFSR lock-up state and can never be verified, so it is refilled.
  always_comb begin
    state_d = state_q;
    if (bit_valid) begin
      unique case (state_q)
        SEED: begin
          if (fill_q == FILL_LAST && s_shift != '0) state_d = VERIFY;
        end
        VERIFY: begin
          if (mismatch) state_d = SEED;
          else if (match_q == 16'(LOCK_CNT - 1)) state_d = LOCKED;
        end
        LOCKED: begin
          if (werr_inc == WERR_W'(ERR_LIMIT)) state_d = SEED;
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_comb begin
    s_d         = s_q;
    fill_d      = fill_q;
    match_d     = match_q;
    window_d    = window_q;
    werr_d      = werr_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
`ifdef PRBS52_WORD_OUT_EN
    wcnt_d       = wcnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
`endif
    if (bit_valid) begin
      unique case (state_q)
        SEED: begin
          s_d     = s_shift;
          fill_d  = (fill_q == FILL_LAST) ? 6'd0 : fill_q + 6'd1;
          match_d = '0;
        end
        VERIFY: begin
          s_d      = s_shift;
          window_d = '0;
          werr_d   = '0;
`ifdef PRBS52_WORD_OUT_EN
          wcnt_d   = '0;
`endif
          if (mismatch) fill_d = '0;
          else          match_d = match_q + 16'd1;
        end
        LOCKED: begin
          // Flywheel: the reference advances on its own prediction, so received errors cannot corrupt it.
          s_d      = s_fly;
          fill_d   = '0;
          window_d = window_q + WIN_W'(1);
          if (bit_count_q != '1) bit_count_d = bit_count_q + CNT_W'(1);
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          end
          werr_d = (window_q == WIN_W'(WINDOW - 1)) ? '0 : werr_inc;
`ifdef PRBS52_WORD_OUT_EN
          if (wcnt_q == FILL_LAST) begin
            wcnt_d       = '0;
            word_d       = s_fly;
            word_valid_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 6'd1;
          end
`endif
        end
        default: begin
          fill_d = '0;
        end
      endcase
    end
    if (clr_counts) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      window_q    <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
`ifdef PRBS52_WORD_OUT_EN
      wcnt_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
`endif
    end else begin
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      window_q    <= window_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
`ifdef PRBS52_WORD_OUT_EN
      wcnt_q       <= wcnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
`endif
    end
  end

  always_comb begin
    locked     = (state_q == LOCKED);
    err_pulse  = err_pulse_q;
    err_count  = err_count_q;
    bit_count  = bit_count_q;
`ifdef PRBS52_WORD_OUT_EN
    word_out   = word_q;
    word_valid = word_valid_q;
`endif
  end

endmodule
